// File: rtl/lockin_photon_counter.sv
// Square-wave lock-in photon counter: N-bin phase timebase, saturating I/Q/total windows.
// Define LOCKIN_HISTOGRAM_EN to add the per-bin phase histogram and its hist_addr/hist_data port.
module lockin_photon_counter #(
    parameter int NUM_BINS      = 4,
    parameter int BIN_CYCLES    = 125,
    parameter int INTEG_PERIODS = 100000,
    parameter int ACC_W         = 32,
    localparam int BIN_W        = $clog2(NUM_BINS)
) (
    input  logic             main_clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pmt_in,
    output logic             light_source,
    output logic             result_valid,
    output logic [ACC_W-1:0] in_phase,
    output logic [ACC_W-1:0] quadrature,
    output logic [ACC_W-1:0] total_count,
`ifdef LOCKIN_HISTOGRAM_EN
    output logic             saturated,
    input  logic [BIN_W-1:0] hist_addr,
    output logic [ACC_W-1:0] hist_data
`else
    output logic             saturated
`endif
);

    localparam int SUB_W = (BIN_CYCLES > 1) ? $clog2(BIN_CYCLES) : 1;
    localparam int PER_W = (INTEG_PERIODS > 1) ? $clog2(INTEG_PERIODS) : 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(BIN_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(INTEG_PERIODS - 1);
    localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);
    localparam logic [BIN_W-1:0] HALF     = BIN_W'(NUM_BINS / 2);
    localparam logic [BIN_W-1:0] QTR      = BIN_W'(NUM_BINS / 4);
    localparam logic [BIN_W-1:0] QTR3     = BIN_W'((3 * NUM_BINS) / 4);

    localparam logic [ACC_W-1:0] I_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] I_MIN   = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] T_MAX   = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] ONE     = ACC_W'(1);
    localparam logic [ACC_W-1:0] NEG_ONE = {ACC_W{1'b1}};

    logic             active;
    logic             running;
    logic [SUB_W-1:0] sub_cnt, sub_nxt;
    logic [BIN_W-1:0] bin_idx, bin_nxt;
    logic [PER_W-1:0] per_cnt, per_nxt;
    logic             bin_end, period_end, window_end;

    logic             pmt_s1, pmt_s2, pmt_s3;
    logic             pulse;

    logic [ACC_W-1:0] i_acc, q_acc, t_acc;
    logic [ACC_W-1:0] i_nxt, q_nxt, t_nxt;
    logic             sat_acc, sat_nxt;
    logic             i_up, q_up;
    logic             i_clip, q_clip, t_clip;

    // active lags enable by one edge so bin 0 starts together with light_source
    assign running    = enable && active;
    assign bin_end    = (sub_cnt == SUB_LAST);
    assign period_end = bin_end && (bin_idx == BIN_LAST);
    assign window_end = running && period_end && (per_cnt == PER_LAST);

    always_comb begin
        sub_nxt = '0;
        bin_nxt = '0;
        per_nxt = '0;
        if (running) begin
            sub_nxt = bin_end ? '0 : sub_cnt + SUB_W'(1);
            bin_nxt = bin_idx;
            per_nxt = per_cnt;
            if (bin_end) begin
                bin_nxt = (bin_idx == BIN_LAST) ? '0 : bin_idx + BIN_W'(1);
            end
            if (period_end) begin
                per_nxt = (per_cnt == PER_LAST) ? '0 : per_cnt + PER_W'(1);
            end
        end
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            active       <= 1'b0;
            sub_cnt      <= '0;
            bin_idx      <= '0;
            per_cnt      <= '0;
            light_source <= 1'b0;
        end else begin
            active       <= enable;
            sub_cnt      <= sub_nxt;
            bin_idx      <= bin_nxt;
            per_cnt      <= per_nxt;
            light_source <= enable && (bin_nxt < HALF);
        end
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            pmt_s1 <= 1'b0;
            pmt_s2 <= 1'b0;
            pmt_s3 <= 1'b0;
        end else begin
            pmt_s1 <= pmt_in;
            pmt_s2 <= pmt_s1;
            pmt_s3 <= pmt_s2;
        end
    end

    assign pulse = running && pmt_s2 && !pmt_s3;
    assign i_up  = (bin_idx < HALF);
    assign q_up  = (bin_idx >= QTR) && (bin_idx < QTR3);

    // A pulse in the window-end cycle seeds the next window instead of the snapshot
    always_comb begin
        i_clip  = i_up ? (i_acc == I_MAX) : (i_acc == I_MIN);
        q_clip  = q_up ? (q_acc == I_MAX) : (q_acc == I_MIN);
        t_clip  = (t_acc == T_MAX);
        i_nxt   = '0;
        q_nxt   = '0;
        t_nxt   = '0;
        sat_nxt = 1'b0;
        if (window_end) begin
            if (pulse) begin
                i_nxt = i_up ? ONE : NEG_ONE;
                q_nxt = q_up ? ONE : NEG_ONE;
                t_nxt = ONE;
            end
        end else if (running) begin
            i_nxt   = i_acc;
            q_nxt   = q_acc;
            t_nxt   = t_acc;
            sat_nxt = sat_acc;
            if (pulse) begin
                if (!i_clip) i_nxt = i_up ? i_acc + ONE : i_acc - ONE;
                if (!q_clip) q_nxt = q_up ? q_acc + ONE : q_acc - ONE;
                if (!t_clip) t_nxt = t_acc + ONE;
                sat_nxt = sat_acc | i_clip | q_clip | t_clip;
            end
        end
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            i_acc   <= '0;
            q_acc   <= '0;
            t_acc   <= '0;
            sat_acc <= 1'b0;
        end else begin
            i_acc   <= i_nxt;
            q_acc   <= q_nxt;
            t_acc   <= t_nxt;
            sat_acc <= sat_nxt;
        end
    end

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid <= 1'b0;
            in_phase     <= '0;
            quadrature   <= '0;
            total_count  <= '0;
            saturated    <= 1'b0;
        end else begin
            result_valid <= window_end;
            if (window_end) begin
                in_phase    <= i_acc;
                quadrature  <= q_acc;
                total_count <= t_acc;
                saturated   <= sat_acc;
            end
        end
    end

`ifdef LOCKIN_HISTOGRAM_EN
    logic [ACC_W-1:0] hist_acc  [NUM_BINS];
    logic [ACC_W-1:0] hist_snap [NUM_BINS];

    always_ff @(posedge main_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                hist_acc[b]  <= '0;
                hist_snap[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (window_end) begin
                    hist_snap[b] <= hist_acc[b];
                    hist_acc[b]  <= (pulse && (bin_idx == BIN_W'(b))) ? ONE : '0;
                end else if (!running) begin
                    hist_acc[b] <= '0;
                end else if (pulse && (bin_idx == BIN_W'(b)) && (hist_acc[b] != T_MAX)) begin
                    hist_acc[b] <= hist_acc[b] + ONE;
                end
            end
        end
    end

    // Non-power-of-two bin counts leave unused addresses, which read as zero
    generate
        if (NUM_BINS == (1 << BIN_W)) begin : g_hist_rd_full
            always_ff @(posedge main_clock or negedge reset_n) begin
                if (!reset_n) hist_data <= '0;
                else          hist_data <= hist_snap[hist_addr];
            end
        end else begin : g_hist_rd_part
            always_ff @(posedge main_clock or negedge reset_n) begin
                if (!reset_n)                          hist_data <= '0;
                else if (hist_addr < BIN_W'(NUM_BINS)) hist_data <= hist_snap[hist_addr];
                else                                   hist_data <= '0;
            end
        end
    endgenerate
`endif

endmodule

// File: doc/lockin_photon_counter.md
# lockin_photon_counter

Parametrised photon-counting lock-in detector for the fluorescence front end. Generates the square-wave light-source modulation and timestamps each PMT pulse against an N-bin modulation phase. Accumulates signed in-phase and quadrature counts plus a total over a window of whole modulation periods, then presents a snapshot with a one-cycle valid strobe. Replaces the fixed 2-phase, single-width counter: nothing is dropped at window boundaries, saturation is reported, and the phase histogram is optional.

## Interface
- NUM_BINS, 4: phase bins per modulation period; multiple of 4, ≥4
- BIN_CYCLES, 125: main_clock cycles per bin; ≥1 (modulation period = NUM_BINS*BIN_CYCLES)
- INTEG_PERIODS, 100000: modulation periods per integration window; ≥1
- ACC_W, 32: accumulator/result width; ≥4
- main_clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run control, synchronous to main_clock
- pmt_in  in  1  PMT discriminator pulse, asynchronous
- light_source  out  1  modulation output; high during bins 0..NUM_BINS/2-1
- result_valid  out  1  one-cycle strobe, snapshot outputs updated
- in_phase  out  ACC_W  signed I result
- quadrature  out  ACC_W  signed Q result
- total_count  out  ACC_W  unsigned pulse total
- saturated  out  1  any accumulator clipped during the snapshotted window
- hist_addr  in  clog2(NUM_BINS)  histogram bin select (macro only)
- hist_data  out  ACC_W  snapshotted count of bin hist_addr (macro only)

## Operation
- Reset: all outputs, timers, accumulators, and sync flops = 0.
- enable low: sub-bin counter, bin index, period counter, and accumulators held at 0; light_source = 0; no result_valid. Snapshot outputs retain their values.
- enable high: sub-bin counter counts 0..BIN_CYCLES-1 and advances the bin (0..NUM_BINS-1, wrap). Bin NUM_BINS-1 wrap advances the period counter (0..INTEG_PERIODS-1, wrap).
- pmt_in path: 2-flop synchroniser, then registered rising-edge detect. A detected edge is a pulse, tagged with the bin current in the detect cycle.
- Per pulse:
  - total += 1.
  - I += +1 if bin < NUM_BINS/2, else −1.
  - Q += +1 if NUM_BINS/4 ≤ bin < 3*NUM_BINS/4, else −1.
- Saturation:
  - I and Q are two's complement and clip at [−2^(ACC_W−1), 2^(ACC_W−1)−1].
  - total clips at 2^ACC_W−1.
  - Any clip sets a sticky window saturation flag.
- Window end is the last cycle of the last bin of period INTEG_PERIODS-1. On the next edge:
  - in_phase, quadrature, total_count, and saturated load the accumulated values, excluding any pulse detected in the end cycle.
  - result_valid = 1 for exactly one cycle.
  - Accumulators and sticky flag restart from that end-cycle pulse's contribution (±1/1), or 0 if none. No pulse is lost.

## Timing
- pmt_in rise to accumulator update: 3 main_clock edges (sync ×2 + detect). Minimum pulse spacing: pmt_in high ≥2 cycles and low ≥2 cycles.
- enable rising: bin 0 and light_source = 1 from the next cycle. First result_valid comes NUM_BINS*BIN_CYCLES*INTEG_PERIODS cycles after that.
- enable falling mid-window: partial window discarded, no strobe.
- light_source is registered, bin-aligned, with no glitches.

## Configuration
- LOCKIN_HISTOGRAM_EN defined:
  - Adds NUM_BINS saturating ACC_W bin counters, snapshotted and cleared with I/Q.
  - hist_data is registered, valid 1 cycle after hist_addr changes.
- Not defined: hist_addr/hist_data ports absent and no bin counter storage.

## Test plan
Defaults for all tests: NUM_BINS=4, BIN_CYCLES=5, INTEG_PERIODS=3, ACC_W=8.
- No pulses, enable high → light_source 10 high/10 low; result_valid every 60 cycles; I=0, Q=0, total=0, saturated=0.
- One pulse per period detected in bin 0 → I=+3, Q=−3, total=3. Same in bin 1 → I=+3, Q=+3. In bin 2 → I=−3, Q=+3.
- ACC_W=4, INTEG_PERIODS=10, two pulses per period in bin 0 → I=+7, Q=−8, total=15, saturated=1; the next pulse-free window gives saturated=0.
- Pulse detected exactly in the window-end cycle (bin 3) → absent from the current result; next window reports I=−1, Q=−1, total=1.
- enable dropped at cycle 30 of a window, raised again → no strobe; first result exactly 60 cycles after the re-enable, with counts from the new window only. reset_n pulsed mid-window → all outputs 0 immediately.
- LOCKIN_HISTOGRAM_EN, one pulse per period in bin 2 → after strobe, hist_addr=2 gives hist_data=3 one cycle later; other bins 0.
